// File: rtl/cud_pkg.sv
// Shared types and defaults for the up/down modulo counter.
package cud_pkg;

    localparam int CUD_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } cud_mode_t;

endpackage

// File: rtl/cud_next_calc.sv
// Combinational next-count and boundary-event logic for one enabled step.
module cud_next_calc
    import cud_pkg::*;
#(
    parameter int WIDTH = CUD_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_max_val,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_ud,
    input  cud_mode_t        i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_up_evt,
    output logic             o_dn_evt,
    output logic             o_done_set
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]   w_range;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;
    logic             w_sat_like;

    // Range is max_val+1, which needs the extra bit when max_val is all ones.
    assign w_range    = {1'b0, i_max_val} + ONE;
    assign w_step     = ({1'b0, i_step} > w_range) ? w_range : {1'b0, i_step};
    assign w_cur      = (i_count > i_max_val) ? {1'b0, i_max_val} : {1'b0, i_count};
    assign w_sum      = w_cur + w_step;
    // True results of these fit in WIDTH bits, so modulo-2^WIDTH math is exact.
    assign w_diff     = w_cur[WIDTH-1:0] - w_step[WIDTH-1:0];
    assign w_wrap_up  = w_sum[WIDTH-1:0] - w_range[WIDTH-1:0];
    assign w_wrap_dn  = w_cur[WIDTH-1:0] + w_range[WIDTH-1:0] - w_step[WIDTH-1:0];
    assign w_sat_like = (i_mode == MODE_SAT) || (i_mode == MODE_ONESHOT);

    always_comb begin
        o_next     = i_count;
        o_up_evt   = 1'b0;
        o_dn_evt   = 1'b0;
        o_done_set = 1'b0;
        if (w_step != '0) begin
            if (i_ud) begin
                if (w_sum > {1'b0, i_max_val}) begin
                    o_up_evt = 1'b1;
                    o_next   = w_sat_like ? i_max_val : w_wrap_up;
                end else begin
                    o_next = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_step <= w_cur) begin
                    o_next = w_diff;
                end else begin
                    o_dn_evt = 1'b1;
                    o_next   = w_sat_like ? '0 : w_wrap_dn;
                end
            end
            o_done_set = (o_up_evt || o_dn_evt) && (i_mode == MODE_ONESHOT);
        end
    end

endmodule

// File: rtl/counter_ud_mod.sv
// Up/down counter over 0..max_val with wrap, saturate and one-shot modes,
// terminal-count pulse and sticky overflow/underflow flags.
module counter_ud_mod
    import cud_pkg::*;
#(
    parameter int               WIDTH   = CUD_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic             ud,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max_val,
    input  cud_mode_t        mode,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             done,
    output logic             at_max,
    output logic             at_zero
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamp;
    logic             w_up_evt;
    logic             w_dn_evt;
    logic             w_done_set;
    logic             w_step_go;

    cud_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count    (r_count),
        .i_max_val  (max_val),
        .i_step     (step),
        .i_ud       (ud),
        .i_mode     (mode),
        .o_next     (w_next),
        .o_up_evt   (w_up_evt),
        .o_dn_evt   (w_dn_evt),
        .o_done_set (w_done_set)
    );

    assign w_load_clamp = (load > max_val) ? max_val : load;
    assign w_step_go    = en && !r_done && !clr && !load_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= RST_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // A boundary event in the same cycle overrides flag_clr.
            r_ovf <= (r_ovf && !flag_clr) || (w_step_go && w_up_evt);
            r_unf <= (r_unf && !flag_clr) || (w_step_go && w_dn_evt);
            if (clr) begin
                r_count <= '0;
                r_done  <= 1'b0;
                r_tc    <= 1'b0;
            end else if (load_en) begin
                r_count <= w_load_clamp;
                r_done  <= 1'b0;
                r_tc    <= 1'b0;
            end else if (w_step_go) begin
                r_count <= w_next;
                r_done  <= w_done_set;
                r_tc    <= w_up_evt || w_dn_evt;
            end else begin
                r_tc    <= 1'b0;
            end
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign ovf     = r_ovf;
    assign unf     = r_unf;
    assign done    = r_done;
    assign at_max  = (r_count == max_val);
    assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_counter_ud_mod.sv
// Self-checking bench for counter_ud_mod: directed vector table, reset
// sequences and a randomized run against an arithmetic reference model.
module tb_counter_ud_mod;
    import cud_pkg::*;

    localparam int         W      = 8;
    localparam logic [7:0] TB_RST = 8'd5;

    logic      clk;
    logic      rstn;
    logic      en;
    logic      clr;
    logic      load_en;
    logic [7:0] load;
    logic      ud;
    logic [7:0] step;
    logic [7:0] max_val;
    cud_mode_t mode;
    logic      flag_clr;
    logic [7:0] count;
    logic      tc;
    logic      ovf;
    logic      unf;
    logic      done;
    logic      at_max;
    logic      at_zero;

    int n_cmp = 0;
    int n_bad = 0;

    int m_count;
    int m_tc;
    int m_ovf;
    int m_unf;
    int m_done;

    typedef struct {
        bit        clr;
        bit        load_en;
        int        load;
        bit        en;
        bit        ud;
        int        step;
        int        mx;
        cud_mode_t mode;
        bit        fc;
        int        ec;
        int        etc_;
        int        eo;
        int        eu;
        int        ed;
    } vec_t;

    vec_t tbl[$];

    counter_ud_mod #(
        .WIDTH   (W),
        .RST_VAL (TB_RST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clr      (clr),
        .load_en  (load_en),
        .load     (load),
        .ud       (ud),
        .step     (step),
        .max_val  (max_val),
        .mode     (mode),
        .flag_clr (flag_clr),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .unf      (unf),
        .done     (done),
        .at_max   (at_max),
        .at_zero  (at_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int idx, input int ec, input int etc_,
                            input int eo, input int eu, input int ed);
        chk({tag, ".count"},   idx, int'(count),   ec);
        chk({tag, ".tc"},      idx, int'(tc),      etc_);
        chk({tag, ".ovf"},     idx, int'(ovf),     eo);
        chk({tag, ".unf"},     idx, int'(unf),     eu);
        chk({tag, ".done"},    idx, int'(done),    ed);
        chk({tag, ".at_max"},  idx, int'(at_max),  (ec == int'(max_val)) ? 1 : 0);
        chk({tag, ".at_zero"}, idx, int'(at_zero), (ec == 0) ? 1 : 0);
    endtask

    task automatic add(input bit c, input bit l, input int ld, input bit e, input bit u,
                       input int st, input int mx, input cud_mode_t md, input bit fc,
                       input int ec, input int etc_, input int eo, input int eu, input int ed);
        vec_t v;
        v.clr = c; v.load_en = l; v.load = ld; v.en = e; v.ud = u;
        v.step = st; v.mx = mx; v.mode = md; v.fc = fc;
        v.ec = ec; v.etc_ = etc_; v.eo = eo; v.eu = eu; v.ed = ed;
        tbl.push_back(v);
    endtask

    // Reference: the counter as plain integer arithmetic modulo max_val+1.
    task automatic model_edge();
        int mx;
        int s;
        int c;
        int t;
        bit up_e;
        bit dn_e;
        mx   = int'(max_val);
        up_e = 1'b0;
        dn_e = 1'b0;
        if (clr) begin
            m_count = 0; m_done = 0; m_tc = 0;
        end else if (load_en) begin
            m_count = (int'(load) > mx) ? mx : int'(load);
            m_done  = 0; m_tc = 0;
        end else if (en && m_done == 0) begin
            s    = (int'(step) > mx + 1) ? mx + 1 : int'(step);
            c    = (m_count > mx) ? mx : m_count;
            m_tc = 0;
            if (s != 0) begin
                t = ud ? c + s : c - s;
                if (t > mx || t < 0) begin
                    up_e = ud;
                    dn_e = !ud;
                    m_tc = 1;
                    if (mode == MODE_WRAP) begin
                        m_count = ((t % (mx + 1)) + (mx + 1)) % (mx + 1);
                    end else begin
                        m_count = ud ? mx : 0;
                        if (mode == MODE_ONESHOT) m_done = 1;
                    end
                end else begin
                    m_count = t;
                end
            end
        end else begin
            m_tc = 0;
        end
        if (flag_clr) begin m_ovf = 0; m_unf = 0; end
        if (up_e) m_ovf = 1;
        if (dn_e) m_unf = 1;
    endtask

    task automatic model_reset();
        m_count = int'(TB_RST); m_tc = 0; m_ovf = 0; m_unf = 0; m_done = 0;
    endtask

    initial begin
        int pick;
        rstn = 1'b1; en = 1'b1; clr = 1'b0; load_en = 1'b1; load = 8'd77;
        ud = 1'b1; step = 8'd1; max_val = 8'd255; mode = MODE_WRAP; flag_clr = 1'b0;

        //        clr ld load en ud step max mode          fc   count tc ovf unf done
        add(1, 0,   0, 0, 1,   3,   9, MODE_WRAP,    0,   0, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1,   3,   9, MODE_WRAP,    0,   3, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1,   3,   9, MODE_WRAP,    0,   6, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1,   3,   9, MODE_WRAP,    0,   9, 0, 0, 0, 0);
        add(0, 0,   0, 1, 1,   3,   9, MODE_WRAP,    0,   2, 1, 1, 0, 0);
        add(0, 0,   0, 0, 1,   3,   9, MODE_WRAP,    0,   2, 0, 1, 0, 0);
        add(0, 1,   8, 0, 1,   3,   9, MODE_WRAP,    0,   8, 0, 1, 0, 0);
        add(0, 0,   0, 1, 1,   3,   9, MODE_WRAP,    1,   1, 1, 1, 0, 0);
        add(0, 0,   0, 0, 1,   3,   9, MODE_WRAP,    1,   1, 0, 0, 0, 0);
        add(0, 1,   5, 0, 0,   4,   9, MODE_SAT,     0,   5, 0, 0, 0, 0);
        add(0, 0,   0, 1, 0,   4,   9, MODE_SAT,     0,   1, 0, 0, 0, 0);
        add(0, 0,   0, 1, 0,   4,   9, MODE_SAT,     0,   0, 1, 0, 1, 0);
        add(0, 0,   0, 1, 0,   4,   9, MODE_SAT,     0,   0, 1, 0, 1, 0);
        add(0, 0,   0, 0, 0,   4,   9, MODE_SAT,     0,   0, 0, 0, 1, 0);
        add(0, 1, 254, 0, 1,   1, 255, MODE_ONESHOT, 0, 254, 0, 0, 1, 0);
        add(0, 0,   0, 1, 1,   1, 255, MODE_ONESHOT, 0, 255, 0, 0, 1, 0);
        add(0, 0,   0, 1, 1,   1, 255, MODE_ONESHOT, 0, 255, 1, 1, 1, 1);
        add(0, 0,   0, 1, 1,   1, 255, MODE_ONESHOT, 0, 255, 0, 1, 1, 1);
        add(0, 1,  10, 0, 1,   1, 255, MODE_ONESHOT, 0,  10, 0, 1, 1, 0);
        add(1, 1,   7, 1, 1,   1, 255, MODE_ONESHOT, 0,   0, 0, 1, 1, 0);
        add(0, 1, 200, 1, 1,   1, 100, MODE_ONESHOT, 0, 100, 0, 1, 1, 0);
        add(0, 0,   0, 0, 1,   1, 100, MODE_WRAP,    1, 100, 0, 0, 0, 0);
        add(0, 0,   0, 1, 0,  30, 100, MODE_WRAP,    0,  70, 0, 0, 0, 0);
        add(0, 0,   0, 1, 0,  80, 100, MODE_WRAP,    0,  91, 1, 0, 1, 0);
        add(0, 0,   0, 1, 0,   0, 100, MODE_WRAP,    0,  91, 0, 0, 1, 0);
        add(0, 0,   0, 1, 1, 200, 100, MODE_WRAP,    0,  91, 1, 1, 1, 0);
        add(0, 0,   0, 0, 1,   1,  50, MODE_WRAP,    0,  91, 0, 1, 1, 0);
        add(0, 0,   0, 1, 0,   1,  50, MODE_SAT,     0,  49, 0, 1, 1, 0);
        add(0, 0,   0, 1, 1,  10,  50, MODE_SAT,     0,  50, 1, 1, 1, 0);
        add(0, 0,   0, 1, 1,  10,  50, MODE_SAT,     0,  50, 1, 1, 1, 0);
        add(0, 0,   0, 0, 1,  10,  50, MODE_SAT,     0,  50, 0, 1, 1, 0);
        add(0, 1,   7, 0, 1,   9,   9, MODE_WRAP,    0,   7, 0, 1, 1, 0);
        add(0, 0,   0, 1, 1,   9,   9, MODE_WRAP,    0,   6, 1, 1, 1, 0);

        // reset held with active inputs: outputs stay at reset values
        #2 rstn = 1'b0;
        #1 chk_outs("rst_async", 0, int'(TB_RST), 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        chk_outs("rst_hold", 0, int'(TB_RST), 0, 0, 0, 0);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            clr = tbl[i].clr; load_en = tbl[i].load_en; load = 8'(tbl[i].load);
            en = tbl[i].en; ud = tbl[i].ud; step = 8'(tbl[i].step);
            max_val = 8'(tbl[i].mx); mode = tbl[i].mode; flag_clr = tbl[i].fc;
            @(posedge clk); #1;
            chk_outs("vec", i, tbl[i].ec, tbl[i].etc_, tbl[i].eo, tbl[i].eu, tbl[i].ed);
        end

        // async reset mid-count while tc is high
        clr = 1'b0; load_en = 1'b0; en = 1'b1; ud = 1'b1; step = 8'd9;
        max_val = 8'd9; mode = MODE_WRAP; flag_clr = 1'b0;
        #1 rstn = 1'b0;
        #1 chk_outs("rst_mid", 0, int'(TB_RST), 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_outs("rst_mid_hold", 0, int'(TB_RST), 0, 0, 0, 0);
        rstn = 1'b1;
        step = 8'd2;
        @(posedge clk); #1;
        chk_outs("rst_first_edge", 0, 7, 0, 0, 0, 0);

        m_count = 7; m_tc = 0; m_ovf = 0; m_unf = 0; m_done = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b0;
                #1 model_reset();
                chk_outs("rand_rst", k, m_count, m_tc, m_ovf, m_unf, m_done);
                rstn = 1'b1;
            end
            clr      = ($urandom_range(0, 39) == 0);
            load_en  = ($urandom_range(0, 19) == 0);
            load     = 8'($urandom_range(0, 255));
            en       = ($urandom_range(0, 3) != 0);
            ud       = 1'($urandom_range(0, 1));
            flag_clr = ($urandom_range(0, 15) == 0);
            pick     = int'($urandom_range(0, 9));
            if (pick == 0)      step = 8'd0;
            else if (pick < 7)  step = 8'(pick);
            else if (pick == 7) step = 8'($urandom_range(0, 255));
            else                step = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                pick = int'($urandom_range(0, 5));
                case (pick)
                    0: max_val = 8'd0;
                    1: max_val = 8'd1;
                    2: max_val = 8'd9;
                    3: max_val = 8'd100;
                    4: max_val = 8'd255;
                    default: max_val = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 29) == 0) mode = cud_mode_t'(2'($urandom_range(0, 2)));
            model_edge();
            @(posedge clk); #1;
            chk_outs("rand", k, m_count, m_tc, m_ovf, m_unf, m_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
